// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//   Parametrised, pipelined two's-complement adder/subtractor. Operands are cut
//   into SLICE-bit segments; stage k sums segment k and registers the carry into
//   stage k+1. Operands travel alongside so later stages can read their segment
//   (skew), and finished segments travel forward so the whole result leaves the
//   last stage together (de-skew). Latency is STAGES cycles, throughput one op
//   per cycle, with a global stall when the output is held.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready is combinational)
//   add1, add2          operands A and B
//   data_in             carry-in (add) / borrow-in (sub)
//   sub                 0: A+B+cin, 1: A-B-borrow
//   out_valid/out_ready result handshake
//   res                 sum / difference
//   data_out            carry out of MSB (sub: 1 = no borrow)
//   ovf                 signed overflow
//   zero                res == 0
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] add1,
  input  logic [WIDTH-1:0] add2,
  input  logic             data_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             data_out,
  output logic             ovf,
  output logic             zero
);

  // Guard the divisor so a bad SLICE reaches the $error below instead of a
  // divide-by-zero during elaboration.
  localparam int SliceSafe = (SLICE >= 1) ? SLICE : 1;
  localparam int STAGES    = (WIDTH / SliceSafe >= 1) ? WIDTH / SliceSafe : 1;

  if (SLICE < 1 || (WIDTH % SliceSafe) != 0) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be a multiple of SLICE and SLICE >= 1");
  end

  // Stage registers; index k holds the state after stage k has run.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];   // B already conditionally inverted
  logic [WIDTH-1:0]  s_q [STAGES];   // completed low segments of the result
  logic              ovf_q;
  logic              zero_q;

  // Per-stage inputs and next-state values.
  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] b_in  [STAGES];
  logic [WIDTH-1:0] s_in  [STAGES];
  logic [WIDTH-1:0] s_nx  [STAGES];
  logic             v_in  [STAGES];
  logic             c_in  [STAGES];
  logic             c_nx  [STAGES];

  logic advance;
  logic ovf_nx;
  logic zero_nx;

  assign advance  = ~v_q[STAGES-1] | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SLICE-1:0] seg_sum;
    logic [WIDTH-1:0] s_merge;

    if (k == 0) begin : g_head
      assign a_in[k] = add1;
      assign b_in[k] = add2 ^ {WIDTH{sub}};
      assign c_in[k] = data_in ^ sub;
      assign s_in[k] = '0;
      assign v_in[k] = in_valid;
    end else begin : g_body
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign s_in[k] = s_q[k-1];
      assign v_in[k] = v_q[k-1];
    end

    assign {c_nx[k], seg_sum} = {1'b0, a_in[k][k*SLICE +: SLICE]}
                              + {1'b0, b_in[k][k*SLICE +: SLICE]}
                              + {{SLICE{1'b0}}, c_in[k]};

    always_comb begin
      s_merge                      = s_in[k];
      s_merge[k*SLICE +: SLICE]    = seg_sum;
    end

    assign s_nx[k] = s_merge;
  end

  // The last stage sees the full result, so the flags are formed there.
  assign ovf_nx  = (a_in[STAGES-1][WIDTH-1] == b_in[STAGES-1][WIDTH-1]) &&
                   (s_nx[STAGES-1][WIDTH-1] != a_in[STAGES-1][WIDTH-1]);
  assign zero_nx = ~|s_nx[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_in[k];
        c_q[k] <= c_nx[k];
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_nx[k];
      end
      ovf_q  <= ovf_nx;
      zero_q <= zero_nx;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign res       = s_q[STAGES-1];
  assign data_out  = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] add1;
  logic [31:0] add2;
  logic        data_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        data_out;
  logic        ovf;
  logic        zero;

  int n_chk  = 0;
  int n_fail = 0;

  pipelined_addsub #(
    .WIDTH(32),
    .SLICE(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .add1     (add1),
    .add2     (add2),
    .data_in  (data_in),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res      (res),
    .data_out (data_out),
    .ovf      (ovf),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic c);
    in_valid = v;
    sub      = s;
    add1     = a;
    add2     = b;
    data_in  = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //        sub  a             b             cin   res           cout  ovf   zero
    vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 32'h00000005, 32'h00000005, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h00001234, 32'h00005678, 1'b1, 32'h000068AD, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 32'h0000FFFF, 32'h0000FFFF, 1'b1, 32'h0001FFFF, 1'b0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset res", res, 32'h0);
    check("reset data_out", 32'(data_out), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset zero", 32'(zero), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Single-op vectors: out_valid low after one edge, result after two.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin);
      step();
      in_valid = 1'b0;
      check($sformatf("vec%0d out_valid early", i), 32'(out_valid), 32'd0);
      step();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d res", i), res, vecs[i].res);
      check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].cout));
      check($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      check($sformatf("vec%0d zero", i), 32'(zero), 32'(vecs[i].zero));
    end
    step();
    check("drain out_valid", 32'(out_valid), 32'd0);

    // Back-pressure: 1+1, 2+2, 3+3, 4+4 with out_ready low for 3 cycles.
    drive(1'b1, 1'b0, 32'd1, 32'd1, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'd2, 32'd2, 1'b0);
    step();
    check("bp first out_valid", 32'(out_valid), 32'd1);
    check("bp first res", res, 32'd2);
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 32'd3, 32'd3, 1'b0);
    #1;
    check("bp in_ready low", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp hold%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp hold%0d res", i), res, 32'd2);
      check($sformatf("bp hold%0d in_ready", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp r2 out_valid", 32'(out_valid), 32'd1);
    check("bp r2 res", res, 32'd4);
    drive(1'b1, 1'b0, 32'd4, 32'd4, 1'b0);
    step();
    check("bp r3 out_valid", 32'(out_valid), 32'd1);
    check("bp r3 res", res, 32'd6);
    in_valid = 1'b0;
    step();
    check("bp r4 out_valid", 32'(out_valid), 32'd1);
    check("bp r4 res", res, 32'd8);
    step();
    check("bp drained", 32'(out_valid), 32'd0);

    // Bubbles: in_valid 1,0,1 gives out_valid 1,0,1 two cycles later.
    drive(1'b1, 1'b0, 32'd10, 32'd1, 1'b0);
    step();
    in_valid = 1'b0;
    check("bub c1 out_valid", 32'(out_valid), 32'd0);
    step();
    drive(1'b1, 1'b0, 32'd20, 32'd2, 1'b0);
    check("bub c2 out_valid", 32'(out_valid), 32'd1);
    check("bub c2 res", res, 32'd11);
    step();
    in_valid = 1'b0;
    check("bub c3 out_valid", 32'(out_valid), 32'd0);
    step();
    check("bub c4 out_valid", 32'(out_valid), 32'd1);
    check("bub c4 res", res, 32'd22);
    step();
    check("bub c5 out_valid", 32'(out_valid), 32'd0);

    // Reset mid-flight, asserted between clock edges.
    drive(1'b1, 1'b1, 32'h80000000, 32'h00000001, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'd3, 32'd4, 1'b0);
    step();
    in_valid = 1'b0;
    check("rst pre out_valid", 32'(out_valid), 32'd1);
    check("rst pre res", res, 32'h7FFFFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst async out_valid", 32'(out_valid), 32'd0);
    check("rst async res", res, 32'h0);
    check("rst async data_out", 32'(data_out), 32'd0);
    check("rst async ovf", 32'(ovf), 32'd0);
    check("rst async zero", 32'(zero), 32'd0);
    check("rst async in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst stale%0d out_valid", i), 32'(out_valid), 32'd0);
    end
    drive(1'b1, 1'b0, 32'd10, 32'd20, 1'b0);
    step();
    in_valid = 1'b0;
    check("rst new early out_valid", 32'(out_valid), 32'd0);
    step();
    check("rst new out_valid", 32'(out_valid), 32'd1);
    check("rst new res", res, 32'h0000001E);
    step();
    check("rst new drained", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
